// File: rtl/branch_offset_encoder.sv
// Two-stage elastic encoder: (pc, target) -> 12-bit halfword branch immediate with error flags.
// Define OFFSET_SAT_EN to clamp the immediate of out-of-range beats to +4094 / -4096.
module branch_offset_encoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      pc,
    input  logic [15:0]      target,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [11:0]      imm,
    output logic             misaligned,
    output logic             overflow,
    output logic [CNT_W-1:0] err_count
);

    logic             s1_valid_q;
    logic [15:0]      diff_q;
    logic             out_valid_q;
    logic [11:0]      imm_q;
    logic             mis_q;
    logic             ovf_q;
    logic [CNT_W-1:0] cnt_q;

    logic             s2_load;
    logic             accept;
    logic             xfer;
    logic [11:0]      imm_d;
    logic             mis_d;
    logic             ovf_d;

    // S1 moves whenever S2 is loading, so in_ready follows out_ready combinationally.
    assign s2_load  = !out_valid_q || out_ready;
    assign in_ready = rst_n && (!s1_valid_q || s2_load);
    assign accept   = in_valid && in_ready;
    assign xfer     = out_valid_q && out_ready;

    always_comb begin
        mis_d = diff_q[0];
        ovf_d = (diff_q[15:13] != {3{diff_q[12]}});
        imm_d = diff_q[12:1];
`ifdef OFFSET_SAT_EN
        if (ovf_d) begin
            imm_d = diff_q[15] ? 12'h800 : 12'h7FF;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            diff_q      <= '0;
            out_valid_q <= 1'b0;
            imm_q       <= '0;
            mis_q       <= 1'b0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            if (in_ready) begin
                s1_valid_q <= accept;
            end
            if (accept) begin
                diff_q <= target - pc;
            end
            if (s2_load) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    imm_q <= imm_d;
                    mis_q <= mis_d;
                    ovf_q <= ovf_d;
                end
            end
            if (xfer && (mis_q || ovf_q) && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign imm        = imm_q;
    assign misaligned = mis_q;
    assign overflow   = ovf_q;
    assign err_count  = cnt_q;

endmodule

// File: tb/tb_branch_offset_encoder.sv
// Directed self-checking bench for branch_offset_encoder; expectations are hand-computed.
// Honours OFFSET_SAT_EN for the overflow immediates.
module tb_branch_offset_encoder;

    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      pc;
    logic [15:0]      target;
    logic             out_valid;
    logic             out_ready;
    logic [11:0]      imm;
    logic             misaligned;
    logic             overflow;
    logic [CNT_W-1:0] err_count;

    int unsigned errors = 0;
    int unsigned checks = 0;

    branch_offset_encoder #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .pc         (pc),
        .target     (target),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .imm        (imm),
        .misaligned (misaligned),
        .overflow   (overflow),
        .err_count  (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single beat through an empty pipeline with out_ready held high.
    task automatic one_beat(input string tag, input logic [15:0] p, input logic [15:0] t,
                            input logic [11:0] e_imm, input logic e_mis, input logic e_ovf,
                            input logic [CNT_W-1:0] e_cnt);
        in_valid = 1'b1;
        pc       = p;
        target   = t;
        #1;
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check({tag, ".lat1_valid"}, 32'(out_valid), 32'd0);
        tick();
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".imm"}, 32'(imm), 32'(e_imm));
        check({tag, ".mis"}, 32'(misaligned), 32'(e_mis));
        check({tag, ".ovf"}, 32'(overflow), 32'(e_ovf));
        tick();
        check({tag, ".drain"}, 32'(out_valid), 32'd0);
        check({tag, ".cnt"}, 32'(err_count), 32'(e_cnt));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        pc        = '0;
        target    = '0;
        #2;
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.in_ready", 32'(in_ready), 32'd0);
        check("rst.imm", 32'(imm), 32'd0);
        check("rst.flags", 32'({misaligned, overflow}), 32'd0);
        check("rst.cnt", 32'(err_count), 32'd0);
        #10 rst_n = 1'b1;
        tick();
        check("rel.in_ready", 32'(in_ready), 32'd1);

        one_beat("basic",  16'h0100, 16'h0110, 12'h008, 1'b0, 1'b0, 8'd0);
        one_beat("neg2",   16'h0200, 16'h01FE, 12'hFFF, 1'b0, 1'b0, 8'd0);
        one_beat("wrap",   16'hFFF0, 16'h0010, 12'h010, 1'b0, 1'b0, 8'd0);
        one_beat("max",    16'h1000, 16'h1FFE, 12'h7FF, 1'b0, 1'b0, 8'd0);
        one_beat("min",    16'h2000, 16'h1000, 12'h800, 1'b0, 1'b0, 8'd0);
`ifdef OFFSET_SAT_EN
        one_beat("ovfpos", 16'h0000, 16'h1000, 12'h7FF, 1'b0, 1'b1, 8'd1);
        one_beat("ovfneg", 16'h1002, 16'h0000, 12'h800, 1'b0, 1'b1, 8'd2);
`else
        one_beat("ovfpos", 16'h0000, 16'h1000, 12'h800, 1'b0, 1'b1, 8'd1);
        one_beat("ovfneg", 16'h1002, 16'h0000, 12'h7FF, 1'b0, 1'b1, 8'd2);
`endif
        one_beat("mis+3",  16'h0100, 16'h0103, 12'h001, 1'b1, 1'b0, 8'd3);
        one_beat("mis-3",  16'h0103, 16'h0100, 12'hFFE, 1'b1, 1'b0, 8'd4);

        // Backpressure: four beats (imm 1..4) against a stalled consumer.
        out_ready = 1'b0;
        pc        = 16'h0000;
        in_valid  = 1'b1;
        target    = 16'h0002;
        #1;
        check("bp.rdy0", 32'(in_ready), 32'd1);
        tick();
        target = 16'h0004;
        check("bp.rdy1", 32'(in_ready), 32'd1);
        tick();
        target = 16'h0006;
        check("bp.valid", 32'(out_valid), 32'd1);
        check("bp.imm_b0", 32'(imm), 32'h001);
        check("bp.rdy_drop", 32'(in_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bp.hold_imm", 32'(imm), 32'h001);
            check("bp.hold_rdy", 32'(in_ready), 32'd0);
            check("bp.hold_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        check("bp.rdy_comb", 32'(in_ready), 32'd1);
        tick();
        target = 16'h0008;
        check("bp.out_b1", 32'(imm), 32'h002);
        check("bp.v_b1", 32'(out_valid), 32'd1);
        tick();
        in_valid = 1'b0;
        check("bp.out_b2", 32'(imm), 32'h003);
        check("bp.v_b2", 32'(out_valid), 32'd1);
        tick();
        check("bp.out_b3", 32'(imm), 32'h004);
        check("bp.v_b3", 32'(out_valid), 32'd1);
        tick();
        check("bp.empty", 32'(out_valid), 32'd0);
        check("bp.cnt", 32'(err_count), 32'd4);

        // Reset with two beats buffered.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        pc        = 16'h0000;
        target    = 16'h0001;
        tick();
        tick();
        in_valid = 1'b0;
        check("mr.pre_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mr.out_valid", 32'(out_valid), 32'd0);
        check("mr.cnt", 32'(err_count), 32'd0);
        check("mr.in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        tick();
        #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mr.no_emit", 32'(out_valid), 32'd0);
        end
        check("mr.cnt_after", 32'(err_count), 32'd0);

        // Counter saturation: 300 misaligned beats at full rate.
        in_valid = 1'b1;
        pc       = 16'h0040;
        target   = 16'h0041;
        for (int i = 0; i < 300; i++) begin
            #1;
            if (in_ready !== 1'b1) check("sat.in_ready", 32'(in_ready), 32'd1);
            tick();
            if (i == 101) check("sat.mid", 32'(err_count), 32'd100);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("sat.valid_off", 32'(out_valid), 32'd0);
        check("sat.cnt", 32'(err_count), 32'd255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
